// File: rtl/hit_pkg.sv
// Shared definitions for the calorimeter hit path: hit record layout,
// field width, io encoding for the hit store port and the packer states.
package hit_pkg;

  localparam int HIT_W = 10;

  // io encoding on the hit store interface
  localparam logic IO_GET = 1'b0;
  localparam logic IO_PUT = 1'b1;

  typedef struct packed {
    logic [HIT_W-1:0] eta;
    logic [HIT_W-1:0] phi;
    logic [HIT_W-1:0] et;
    logic [HIT_W-1:0] e;
  } hit_t;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HDR     = 2'd1,
    SEND    = 2'd2,
    TRL     = 2'd3
  } pack_state_t;

endpackage

// File: rtl/hit_buf.sv
// Hit storage for one event: DEPTH x hit_t register array.
// Ports:
//   clk   - clock
//   we    - write enable
//   waddr - write slot
//   wdata - hit to store
//   raddr - read slot (combinational read)
//   rdata - hit stored at raddr
// Contents are not reset; the packer only reads slots it has written
// during the current event.
module hit_buf
  import hit_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  hit_t          wdata,
  input  logic [AW-1:0] raddr,
  output hit_t          rdata
);

  hit_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/hit_pack.sv
// Transmit-side hit packer. Collects one event's hits, drops those with
// et below thresh, buffers up to DEPTH of them, then emits a header beat
// (eta = hit count) followed by the buffered hits in arrival order as
// put-mode beats toward the hit store write port.
//
// Optional build macro: HIT_PACK_ETSUM_EN adds a trailer beat carrying the
// saturating et sum of the stored hits.
//
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   in_valid/in_ready - input hit handshake; in_last marks end of event
//   in_eta/phi/et/e   - input hit fields
//   thresh            - et zero-suppression threshold
//   out_valid/out_ready - output beat handshake
//   out_io            - 1 (put) on every valid beat
//   out_hdr/out_trl   - header / trailer beat flags
//   out_eta/phi/et/e  - beat payload
//   overflow          - sticky: current event dropped a qualifying hit
module hit_pack
  import hit_pkg::*;
#(
  parameter int W     = HIT_W,
  parameter int DEPTH = 32,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_last,
  input  logic [W-1:0] in_eta,
  input  logic [W-1:0] in_phi,
  input  logic [W-1:0] in_et,
  input  logic [W-1:0] in_e,
  input  logic [W-1:0] thresh,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_io,
  output logic         out_hdr,
  output logic         out_trl,
  output logic [W-1:0] out_eta,
  output logic [W-1:0] out_phi,
  output logic [W-1:0] out_et,
  output logic [W-1:0] out_e,
  output logic         overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  pack_state_t      state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] rd;
  logic [CNT_W-1:0] cnt_nxt;
  logic             in_acc;
  logic             out_acc;
  logic             qual;
  logic             store;
  logic             drop;
  hit_t             wr_hit;
  hit_t             rd_hit;

  assign in_acc  = in_valid && in_ready;
  assign out_acc = out_valid && out_ready;
  assign qual    = in_acc && (in_et >= thresh);
  assign store   = qual && (count < CNT_W'(DEPTH));
  assign drop    = qual && !store;
  assign cnt_nxt = store ? count + CNT_W'(1) : count;
  assign wr_hit  = '{eta: in_eta, phi: in_phi, et: in_et, e: in_e};

  hit_buf #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .we    (store),
    .waddr (count[AW-1:0]),
    .wdata (wr_hit),
    .raddr (rd[AW-1:0]),
    .rdata (rd_hit)
  );

`ifdef HIT_PACK_ETSUM_EN
  logic [W-1:0] etsum;
  logic         trl_q;

  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[W] ? {W{1'b1}} : s[W-1:0];
  endfunction

  assign out_trl = trl_q;
`else
  assign out_trl = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= COLLECT;
      count     <= '0;
      rd        <= '0;
      overflow  <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_io    <= 1'b0;
      out_hdr   <= 1'b0;
      out_eta   <= '0;
      out_phi   <= '0;
      out_et    <= '0;
      out_e     <= '0;
`ifdef HIT_PACK_ETSUM_EN
      etsum     <= '0;
      trl_q     <= 1'b0;
`endif
    end else begin
      case (state)
        COLLECT: begin
          in_ready <= 1'b1;
          count    <= cnt_nxt;
          if (drop) overflow <= 1'b1;
`ifdef HIT_PACK_ETSUM_EN
          if (store) etsum <= sat_add(etsum, in_et);
`endif
          // The last beat is counted first, so the header carries the
          // final count including that beat.
          if (in_acc && in_last) begin
            state     <= HDR;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
            out_io    <= IO_PUT;
            out_hdr   <= 1'b1;
            out_eta   <= W'(cnt_nxt);
            out_phi   <= '0;
            out_et    <= '0;
            out_e     <= '0;
          end
        end

        // rd is the next slot to present; the header transfer loads slot 0.
        HDR, SEND: begin
          if (out_acc) begin
            if (rd < count) begin
              state   <= SEND;
              out_hdr <= 1'b0;
              out_eta <= rd_hit.eta;
              out_phi <= rd_hit.phi;
              out_et  <= rd_hit.et;
              out_e   <= rd_hit.e;
              rd      <= rd + CNT_W'(1);
            end else begin
`ifdef HIT_PACK_ETSUM_EN
              state   <= TRL;
              out_hdr <= 1'b0;
              trl_q   <= 1'b1;
              out_eta <= '0;
              out_phi <= '0;
              out_et  <= etsum;
              out_e   <= '0;
`else
              state     <= COLLECT;
              count     <= '0;
              rd        <= '0;
              overflow  <= 1'b0;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              out_io    <= 1'b0;
              out_hdr   <= 1'b0;
              out_eta   <= '0;
              out_phi   <= '0;
              out_et    <= '0;
              out_e     <= '0;
`endif
            end
          end
        end

`ifdef HIT_PACK_ETSUM_EN
        TRL: begin
          if (out_acc) begin
            state     <= COLLECT;
            count     <= '0;
            rd        <= '0;
            overflow  <= 1'b0;
            etsum     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_io    <= 1'b0;
            trl_q     <= 1'b0;
            out_et    <= '0;
          end
        end
`endif

        default: state <= COLLECT;
      endcase
    end
  end

endmodule
